// File: rtl/aclk_controller.sv
// aclk_controller: main sequencing FSM of the alarm clock.
//   clk_i           system clock (shared with aclk_timegen)
//   reset_i         asynchronous active-low reset
//   one_second_i    1-cycle seconds tick from aclk_timegen
//   key_i[3:0]      keypad code, 0-9 digit, anything else idle
//   alarm_button_i  level, alarm button held
//   time_button_i   level, time button held
//   shift_o         shift current digit into key buffer
//   load_new_a_o    load key buffer into alarm register
//   load_new_c_o    load key buffer into minute counter
//   reset_count_o   restart timegen prescaler
//   show_a_o        LCD shows alarm time
//   show_new_time_o LCD shows key buffer
module aclk_controller #(
   parameter int         TIMEOUT_SEC = 10,
   parameter logic [3:0] NOKEY       = 4'd10
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       one_second_i,
   input  logic [3:0] key_i,
   input  logic       alarm_button_i,
   input  logic       time_button_i,
   output logic       shift_o,
   output logic       load_new_a_o,
   output logic       load_new_c_o,
   output logic       reset_count_o,
   output logic       show_a_o,
   output logic       show_new_time_o
);
   localparam int TW = $clog2(TIMEOUT_SEC);
   typedef enum logic [2:0] {
      SHOW_TIME, KEY_STORED, KEY_WAITED, KEY_ENTRY, SHOW_ALARM, SET_ALARM_TIME, SET_CURRENT_TIME
   } state_e;
   state_e          state_q, state_d;
   logic [TW-1:0]   tcnt_q, tcnt_d;
   logic            valid_key, in_entry, timeout;
   // codes from NOKEY upward (10-15) are all treated as "no key"
   assign valid_key = key_i < NOKEY;
   assign in_entry  = state_q == KEY_WAITED || state_q == KEY_ENTRY;
   assign timeout   = in_entry && one_second_i && tcnt_q == TW'(TIMEOUT_SEC - 1);
   // window only runs while waiting for the next digit; KEY_STORED clears it so
   // every press restarts the full timeout
   assign tcnt_d    = (!in_entry || timeout) ? '0 : tcnt_q + TW'(one_second_i);
   always_comb begin
      state_d = state_q;
      case (state_q)
         SHOW_TIME:  state_d = alarm_button_i ? SHOW_ALARM : valid_key ? KEY_STORED : SHOW_TIME;
         KEY_STORED: state_d = KEY_WAITED;
         KEY_WAITED: state_d = timeout ? SHOW_TIME : !valid_key ? KEY_ENTRY : KEY_WAITED;
         KEY_ENTRY:  state_d = timeout ? SHOW_TIME : alarm_button_i ? SET_ALARM_TIME :
                               time_button_i ? SET_CURRENT_TIME : valid_key ? KEY_STORED : KEY_ENTRY;
         SHOW_ALARM: state_d = alarm_button_i ? SHOW_ALARM : SHOW_TIME;
         default:    state_d = SHOW_TIME;
      endcase
   end
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q <= SHOW_TIME;
         tcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         tcnt_q  <= tcnt_d;
      end
   end
   assign shift_o         = state_q == KEY_STORED;
   assign show_new_time_o = state_q == KEY_STORED || in_entry;
   assign show_a_o        = state_q == SHOW_ALARM;
   assign load_new_a_o    = state_q == SET_ALARM_TIME;
   assign load_new_c_o    = state_q == SET_CURRENT_TIME;
   assign reset_count_o   = state_q == SET_CURRENT_TIME;
endmodule

// File: tb/tb_aclk_controller.sv
// tb_aclk_controller: scenario and randomized checks of aclk_controller against a behavioural model.
module tb_aclk_controller;
   localparam int TO = 10;
   localparam logic [3:0] NK = 4'd10;
   logic       clk = 0, reset_n = 0, one_second = 0, alarm_button = 0, time_button = 0;
   logic [3:0] key = NK;
   logic       shift, load_new_a, load_new_c, reset_count, show_a, show_new_time;
   int         errors = 0, checks = 0;
   // model: mode 0 clock view, 1 alarm view, 2 entering digits, 3 alarm load, 4 clock load
   int         m_mode = 0, m_secs = 0;
   bit         m_fresh = 0, m_held = 0;

   aclk_controller #(.TIMEOUT_SEC(TO), .NOKEY(NK)) dut (
      .clk_i(clk), .reset_i(reset_n), .one_second_i(one_second), .key_i(key),
      .alarm_button_i(alarm_button), .time_button_i(time_button),
      .shift_o(shift), .load_new_a_o(load_new_a), .load_new_c_o(load_new_c),
      .reset_count_o(reset_count), .show_a_o(show_a), .show_new_time_o(show_new_time));

   always #5 clk = ~clk;

   function automatic logic [5:0] obs();
      return {shift, show_new_time, show_a, load_new_a, load_new_c, reset_count};
   endfunction

   function automatic logic [5:0] mexp();
      return {m_mode == 2 && m_fresh, m_mode == 2, m_mode == 1, m_mode == 3, m_mode == 4, m_mode == 4};
   endfunction

   task automatic mreset();
      m_mode = 0; m_secs = 0; m_fresh = 0; m_held = 0;
   endtask

   task automatic mstep(input logic [3:0] k, input bit ab, input bit tb, input bit os);
      bit v = k <= 9;
      case (m_mode)
         0: if (ab) m_mode = 1; else if (v) begin m_mode = 2; m_fresh = 1; m_secs = 0; end
         1: if (!ab) m_mode = 0;
         2: if (m_fresh) begin
               m_fresh = 0; m_held = 1; m_secs = 0;
            end else if (os && m_secs == TO - 1) m_mode = 0;
            else begin
               m_secs += int'(os);
               if (m_held) m_held = v;
               else if (ab) m_mode = 3;
               else if (tb) m_mode = 4;
               else if (v) m_fresh = 1;
            end
         default: m_mode = 0;
      endcase
      if (m_mode != 2) begin m_fresh = 0; m_held = 0; m_secs = 0; end
   endtask

   task automatic tick(input logic [3:0] k, input bit ab, input bit tb, input bit os);
      key = k; alarm_button = ab; time_button = tb; one_second = os;
      @(posedge clk);
      mstep(k, ab, tb, os);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 0;
      #12;
      checks++; if (obs() !== 6'b0) begin errors++; $display("FAIL reset_init: got %b want %b", obs(), 6'b0); end
      @(negedge clk); reset_n = 1; mreset();
      tick(4'd1, 0, 0, 0); tick(4'd1, 0, 0, 0); tick(NK, 0, 0, 0);
      for (int i = 0; i < 5; i++) tick(NK, 0, 0, 1);
      checks++; if (obs() !== mexp()) begin errors++; $display("FAIL reset_pre: got %b want %b", obs(), mexp()); end
      #2 reset_n = 0; mreset();
      #1;
      checks++; if (obs() !== 6'b0) begin errors++; $display("FAIL reset_async: got %b want %b", obs(), 6'b0); end
      @(negedge clk); reset_n = 1;
      tick(NK, 0, 0, 0);
      checks++; if (obs() !== 6'b0) begin errors++; $display("FAIL reset_after: got %b want %b", obs(), 6'b0); end
   endtask

   task automatic test_digit_entry();
      int pulses = 0, snt_low = 0;
      for (int d = 1; d <= 4; d++) begin
         for (int c = 0; c < 3; c++) begin
            tick(4'(d), 0, 0, 0);
            pulses += int'(shift); snt_low += int'(!show_new_time);
            checks++; if (obs() !== mexp()) begin errors++; $display("FAIL digit_cycle: got %b want %b", obs(), mexp()); end
         end
         tick(NK, 0, 0, 0);
         pulses += int'(shift); snt_low += int'(!show_new_time);
      end
      checks++; if (pulses != 4) begin errors++; $display("FAIL digit_shifts: got %0d want %0d", pulses, 4); end
      checks++; if (snt_low != 0) begin errors++; $display("FAIL digit_show: got %0d low cycles want 0", snt_low); end
   endtask

   task automatic test_set_time();
      tick(NK, 0, 1, 0);
      checks++; if (obs() !== 6'b000011) begin errors++; $display("FAIL set_time_strobe: got %b want %b", obs(), 6'b000011); end
      tick(NK, 0, 0, 0);
      checks++; if (obs() !== 6'b0) begin errors++; $display("FAIL set_time_after: got %b want %b", obs(), 6'b0); end
   endtask

   task automatic test_timeout();
      int loads = 0;
      tick(4'd7, 0, 0, 0); tick(NK, 0, 0, 0);
      for (int i = 1; i <= TO; i++) begin
         tick(NK, 0, 0, 0); tick(NK, 0, 0, 1);
         loads += int'(load_new_a | load_new_c);
         checks++; if (show_new_time !== (i < TO)) begin errors++; $display("FAIL timeout_tick%0d: got %b want %b", i, show_new_time, i < TO); end
      end
      checks++; if (loads != 0) begin errors++; $display("FAIL timeout_noload: got %0d want 0", loads); end
      tick(4'd3, 0, 0, 0); tick(NK, 0, 0, 0);
      for (int i = 0; i < TO - 1; i++) tick(NK, 0, 0, 1);
      tick(4'd4, 0, 0, 0); tick(NK, 0, 0, 0);
      for (int i = 0; i < TO - 1; i++) tick(NK, 0, 0, 1);
      checks++; if (obs() !== 6'b010000) begin errors++; $display("FAIL timeout_restart: got %b want %b", obs(), 6'b010000); end
      tick(NK, 0, 0, 1);
      checks++; if (obs() !== 6'b0) begin errors++; $display("FAIL timeout_restart_exit: got %b want %b", obs(), 6'b0); end
   endtask

   task automatic test_alarm();
      int n = 0;
      for (int i = 0; i < 5; i++) begin tick(NK, 1, 0, 0); n += int'(show_a); end
      tick(NK, 0, 0, 0);
      checks++; if (n != 5 || show_a !== 1'b0) begin errors++; $display("FAIL alarm_show: got %0d cycles end %b want 5 end 0", n, show_a); end
      tick(4'd5, 0, 0, 0); tick(NK, 0, 0, 0); tick(NK, 0, 0, 0);
      tick(NK, 1, 1, 0);
      checks++; if (obs() !== 6'b000100) begin errors++; $display("FAIL alarm_load: got %b want %b", obs(), 6'b000100); end
      tick(NK, 1, 0, 0);
      checks++; if (obs() !== 6'b0) begin errors++; $display("FAIL alarm_after: got %b want %b", obs(), 6'b0); end
      tick(NK, 1, 0, 0);
      checks++; if (obs() !== 6'b001000) begin errors++; $display("FAIL alarm_reenter: got %b want %b", obs(), 6'b001000); end
      tick(NK, 0, 0, 0);
   endtask

   task automatic test_priority();
      tick(4'd9, 0, 0, 0); tick(NK, 0, 0, 0);
      for (int i = 0; i < TO - 1; i++) tick(NK, 0, 0, 1);
      tick(NK, 0, 1, 1);
      checks++; if (obs() !== 6'b0) begin errors++; $display("FAIL priority_timeout: got %b want %b", obs(), 6'b0); end
      tick(4'd2, 1, 0, 0);
      checks++; if (obs() !== 6'b001000) begin errors++; $display("FAIL priority_button_key: got %b want %b", obs(), 6'b001000); end
      tick(NK, 0, 0, 0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         logic [3:0] k = ($urandom_range(0, 1) == 0) ? NK : 4'($urandom_range(0, 15));
         tick(k, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
         checks++; if (obs() !== mexp()) begin errors++; $display("FAIL random_%0d: got %b want %b", i, obs(), mexp()); end
      end
   endtask

   initial begin
      test_reset();
      test_digit_entry();
      test_set_time();
      test_timeout();
      test_alarm();
      test_priority();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
